// File: rtl/serial_mem_loader.sv
// serial_mem_loader: front-end write controller for the latch-based byte memory banks.
// Assembles one DATA_W-bit word from an LSB-first serial stream, then drives it together with
// a one-hot bank write strobe for WR_CYCLES cycles and pulses done for one cycle.
//
// Ports:
//   clk    - single clock, rising edge
//   rst_n  - asynchronous active-low reset
//   start  - load request, accepted only while ready=1
//   addr   - target bank, captured on the accepting edge
//   sin    - serial data, LSB first (don't-care outside SHIFT)
//   ready  - high only in IDLE
//   d      - registered parallel word to the banks, changes only on SHIFT->WRITE and reset
//   we     - registered one-hot bank write strobe, high only in WRITE
//   done   - one-cycle pulse after the write window completes
module serial_mem_loader #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned ADDR_W    = 2,
  parameter int unsigned WR_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [ADDR_W-1:0]      addr,
  input  logic                   sin,
  output logic                   ready,
  output logic [DATA_W-1:0]      d,
  output logic [2**ADDR_W-1:0]   we,
  output logic                   done
);

  localparam int unsigned NumBanks = 2 ** ADDR_W;
  localparam int unsigned BitCntW  = $clog2(DATA_W + 1);
  localparam logic [BitCntW-1:0] BitLast = BitCntW'(DATA_W - 1);
  localparam logic [3:0]         WrLast  = 4'(WR_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StShift, StWrite, StDone} state_e;

  state_e               state_q, state_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  // Holds the DATA_W-1 samples already received; the last sample goes straight into d.
  logic [DATA_W-2:0]    sr_q, sr_d;
  logic [DATA_W-1:0]    d_q, d_d;
  logic [BitCntW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [3:0]           wr_cnt_q, wr_cnt_d;
  logic [NumBanks-1:0]  we_q, we_d;
  logic [DATA_W-1:0]    shifted;
  logic                 accept;
  logic                 last_bit;

  assign accept   = (state_q == StIdle) && start;
  assign last_bit = (state_q == StShift) && (bit_cnt_q == BitLast);
  assign shifted  = {sin, sr_q};

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StShift;
      StShift: if (bit_cnt_q == BitLast) state_d = StWrite;
      StWrite: if (wr_cnt_q == WrLast) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded from state; we is registered separately so it cannot glitch.
  always_comb begin
    ready = (state_q == StIdle);
    done  = (state_q == StDone);
    we    = we_q;
    d     = d_q;
  end

  // Datapath next-state
  always_comb begin
    addr_d    = addr_q;
    sr_d      = sr_q;
    d_d       = d_q;
    bit_cnt_d = bit_cnt_q;
    wr_cnt_d  = wr_cnt_q;

    if (accept) begin
      addr_d    = addr;
      bit_cnt_d = '0;
    end

    if (state_q == StShift) begin
      sr_d      = shifted[DATA_W-1:1];
      bit_cnt_d = bit_cnt_q + BitCntW'(1);
    end

    if (last_bit) begin
      d_d      = shifted;
      wr_cnt_d = '0;
    end

    if (state_q == StWrite) begin
      wr_cnt_d = wr_cnt_q + 4'd1;
    end

    // Strobe follows the state being entered, so it rises on entry to WRITE and falls on
    // the edge that enters DONE.
    we_d = '0;
    if (state_d == StWrite) begin
      we_d = NumBanks'(1) << addr_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q    <= '0;
      sr_q      <= '0;
      d_q       <= '0;
      bit_cnt_q <= '0;
      wr_cnt_q  <= '0;
      we_q      <= '0;
    end else begin
      addr_q    <= addr_d;
      sr_q      <= sr_d;
      d_q       <= d_d;
      bit_cnt_q <= bit_cnt_d;
      wr_cnt_q  <= wr_cnt_d;
      we_q      <= we_d;
    end
  end

endmodule

// File: tb/tb_serial_mem_loader.sv
// Directed self-checking bench for serial_mem_loader: a default-parameter instance plus a
// DATA_W=5 / WR_CYCLES=1 instance sharing clock and reset.
module tb_serial_mem_loader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       sin = 1'b0;
  logic [1:0] addr = 2'd0;
  logic       ready;
  logic [7:0] d;
  logic [3:0] we;
  logic       done;

  logic       start2 = 1'b0;
  logic       sin2 = 1'b0;
  logic [1:0] addr2 = 2'd0;
  logic       ready2;
  logic [4:0] d2;
  logic [3:0] we2;
  logic       done2;

  int         n_tests = 0;
  int         n_fail = 0;
  logic [7:0] d_exp = 8'h00;
  logic [7:0] bank [4];
  logic [3:0] we_exp;
  logic [4:0] val5;
  logic [7:0] val8;

  serial_mem_loader #(.DATA_W(8), .ADDR_W(2), .WR_CYCLES(2)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .addr  (addr),
    .sin   (sin),
    .ready (ready),
    .d     (d),
    .we    (we),
    .done  (done)
  );

  serial_mem_loader #(.DATA_W(5), .ADDR_W(2), .WR_CYCLES(1)) u_dut5 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start2),
    .addr  (addr2),
    .sin   (sin2),
    .ready (ready2),
    .d     (d2),
    .we    (we2),
    .done  (done2)
  );

  always #5 clk = ~clk;

  // Simple bank model: a bank captures d on a clock edge while its strobe is high.
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) bank[i] <= d;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full load on the 8-bit instance; k counts edges after the accepting edge.
  task automatic load1(input logic [1:0] a, input logic [7:0] data, input bit keep_start,
                       input bit poke);
    logic [3:0] onehot;
    onehot = 4'b0001 << a;
    start = 1'b1;
    addr  = a;
    tick();
    start = keep_start;
    addr  = ~a;
    for (int k = 1; k <= 11; k++) begin
      sin = (k <= 8) ? data[k-1] : 1'($urandom);
      if (poke) begin
        start = (k == 3);
        addr  = 2'd3;
      end
      tick();
      we_exp = (k == 8 || k == 9) ? onehot : 4'b0000;
      chk("we", 32'(we), 32'(we_exp));
      chk("done", 32'(done), 32'(k == 10));
      chk("ready", 32'(ready), 32'(k == 11));
      chk("d", 32'(d), 32'((k >= 8) ? data : d_exp));
    end
    d_exp = data;
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_we", 32'(we), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_d", 32'(d), 32'd0);
    chk("rst_ready5", 32'(ready2), 32'd1);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("idle_ready", 32'(ready), 32'd1);

    // Single load 0xA5 to bank 2
    load1(2'd2, 8'hA5, 1'b0, 1'b0);
    chk("bank2", 32'(bank[2]), 32'hA5);

    // Start pulsed with addr=3 during SHIFT of an addr=0 load
    load1(2'd0, 8'h3C, 1'b0, 1'b1);
    chk("bank0", 32'(bank[0]), 32'h3C);
    for (int k = 0; k < 12; k++) begin
      tick();
      chk("busy_we", 32'(we), 32'd0);
      chk("busy_ready", 32'(ready), 32'd1);
      chk("busy_d", 32'(d), 32'h3C);
    end

    // Back-to-back with start held high
    load1(2'd1, 8'hFF, 1'b1, 1'b0);
    load1(2'd3, 8'h00, 1'b1, 1'b0);
    start = 1'b0;
    tick();
    chk("b2b_bank1", 32'(bank[1]), 32'hFF);
    chk("b2b_bank3", 32'(bank[3]), 32'h00);
    chk("b2b_idle", 32'(ready), 32'd1);

    // Reset in first WRITE cycle
    load1(2'd1, 8'h55, 1'b0, 1'b0);
    chk("bank1_55", 32'(bank[1]), 32'h55);
    val8  = 8'hAA;
    start = 1'b1;
    addr  = 2'd1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      sin = val8[k-1];
      tick();
    end
    chk("rw_we", 32'(we), 32'b0010);
    chk("rw_d", 32'(d), 32'hAA);
    rst_n = 1'b0;
    #1;
    chk("rw_we0", 32'(we), 32'd0);
    chk("rw_ready", 32'(ready), 32'd1);
    chk("rw_done", 32'(done), 32'd0);
    chk("rw_d0", 32'(d), 32'd0);
    tick();
    chk("rw_bank1", 32'(bank[1]), 32'h55);
    rst_n = 1'b1;
    d_exp = 8'h00;
    tick();
    load1(2'd1, 8'hC3, 1'b0, 1'b0);
    chk("fresh_bank1", 32'(bank[1]), 32'hC3);

    // DATA_W=5, WR_CYCLES=1 instance
    val5   = 5'h13;
    start2 = 1'b1;
    addr2  = 2'd3;
    tick();
    start2 = 1'b0;
    addr2  = 2'd0;
    for (int k = 1; k <= 7; k++) begin
      sin2 = (k <= 5) ? val5[k-1] : 1'b0;
      tick();
      we_exp = (k == 5) ? 4'b1000 : 4'b0000;
      chk("p_we", 32'(we2), 32'(we_exp));
      chk("p_done", 32'(done2), 32'(k == 6));
      chk("p_ready", 32'(ready2), 32'(k == 7));
      chk("p_d", 32'(d2), 32'((k >= 5) ? val5 : 5'h00));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
